mc_control: RTL and testbench
=============================

# mc_control

Multicycle control unit for the EC413 CPU: a Moore state machine that sequences the shared datapath (PC, instruction register, register file, single ALU, data memory) through fetch, decode, execute, memory and write-back steps. It takes the opcode of the latched instruction and the ALU zero flag, and drives every datapath strobe and mux select. It also keeps a retired-instruction counter and a sticky illegal-opcode flag for bench visibility.

## Interface
- `PC_W`, default 16: instruction counter width; matches the PC width.
- `clk`, input, 1: single system clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `opcode`, input, 6: IR[31:26] of the latched instruction.
- `zero`, input, 1: ALU result == 0.
- `ir_write`, output, 1: load the IR from instruction memory.
- `pc_write`, output, 1: load the PC.
- `pc_src`, output, 2: selects the next PC. 0 = PC+1; 1 = PC + sext(IR[15:0]), where PC is already incremented; 2 = IR[15:0] absolute.
- `alu_src_b`, output, 1: selects ALU B. 0 = register; 1 = extended immediate.
- `imm_zext`, output, 1: selects the immediate extension. 1 = zero-extend; 0 = sign-extend.
- `rb_sel`, output, 1: selects the second read port. 0 = IR[15:11]; 1 = IR[25:21].
- `alu_op`, output, 3: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLT (signed), 5 PASS_A, 6 PASS_B.
- `reg_write`, output, 1: write the register file at IR[25:21].
- `mem_to_reg`, output, 1: selects the write-back source. 1 = memory data; 0 = ALU output register.
- `mem_read`, output, 1: data memory read strobe.
- `mem_write`, output, 1: data memory write strobe.
- `state`, output, 4: current state encoding (debug).
- `instr_count`, output, `PC_W`: count of retired instructions.
- `illegal`, output, 1: sticky flag; set on an undefined opcode.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LS, MEM_RD, MEM_WR, WB, BRANCH, JUMP.
- FETCH: ir_write=1, pc_write=1, pc_src=0. Always goes to DECODE.
- DECODE: no strobes. Next state depends on opcode:
  - 010000 (MOV), 010010 (ADD), 010011 (SUB), 010100 (OR), 010101 (AND), 010111 (SLT) go to EXEC_R.
  - 110010 (ADDI), 110011 (SUBI), 110100 (ORI), 110101 (ANDI), 110111 (SLTI), 111001 (LI) go to EXEC_I.
  - 111011 (LWI) and 111100 (SWI) go to EXEC_LS.
  - 100001 (BNE) goes to BRANCH.
  - 000001 (J) goes to JUMP.
  - 000000 (NOP) goes to FETCH.
  - Any other opcode goes to FETCH and sets `illegal`.
- EXEC_R: alu_src_b=0, rb_sel=0. alu_op per opcode; MOV uses PASS_A. Goes to WB.
- EXEC_I: alu_src_b=1. ORI/ANDI use imm_zext=1; all others use 0. LI uses PASS_B. Goes to WB.
- EXEC_LS: alu_src_b=1, imm_zext=1, alu_op=PASS_B, which forms the address. Goes to MEM_RD for LWI, MEM_WR for SWI.
- MEM_RD: mem_read=1. Goes to WB.
- MEM_WR: mem_write=1, rb_sel=1 (store data comes from IR[25:21]). Goes to FETCH.
- WB: reg_write=1. mem_to_reg=1 only for LWI. Goes to FETCH.
- BRANCH: alu_op=SUB, alu_src_b=0, rb_sel=1, pc_src=1. pc_write = ~zero. Goes to FETCH.
- JUMP: pc_src=2, pc_write=1. Goes to FETCH.
- Outputs not listed for a state are 0.
- Retire: `instr_count` increments on every transition into FETCH from a state other than FETCH, including the NOP/illegal DECODE→FETCH path. It wraps from all-ones to 0.

## Timing
- Cycles per instruction: NOP/illegal 2; BNE, J 3; ALU, LI, SWI 4; LWI 5.
- Outputs are Moore, decoded from `state` plus the registered `opcode`. `zero` is sampled only in BRANCH, in the same cycle.
- `rst` asserted at any time, including mid-instruction:
  - state goes to FETCH immediately;
  - instr_count = 0, illegal = 0;
  - all strobes are forced to 0 while `rst` is high.
- The first fetch strobe occurs in the first cycle after `rst` deasserts.
- A partially executed instruction is abandoned with no write.
- `illegal` and a counter increment in the same cycle are both applied.

## Structure
- Package `mc_defs`: opcode localparams, state encodings, alu_op codes, pc_src codes.
- One sub-module, `mc_opdecode` (combinational), maps opcode to an instruction class, the alu_op, imm_zext and the illegal indication.
- The FSM, registered outputs and counter live in `mc_control`.

## Test plan
- Reset release, then opcode=110010 (ADDI): states FETCH, DECODE, EXEC_I, WB, FETCH. alu_src_b=1, imm_zext=0 in EXEC_I; reg_write=1 only in WB; instr_count=1.
- LWI then SWI: LWI takes 5 cycles with mem_read in cycle 4 and mem_to_reg=reg_write=1 in cycle 5. SWI asserts mem_write with rb_sel=1 in cycle 4 and never asserts reg_write.
- BNE with zero=0 → pc_write=1, pc_src=1 in cycle 3. BNE with zero=1 → pc_write=0. Both retire in 3 cycles.
- J → pc_src=2, pc_write=1 in cycle 3. NOP → 2 cycles. opcode=111111 → 2 cycles, illegal=1, and it stays 1 through following valid instructions.
- Assert rst during MEM_RD → state=FETCH and all outputs 0 within the same cycle, counter=0. After release, a normal fetch occurs.
- Preload instr_count to 16'hFFFF (via forced run) and retire one instruction → instr_count=0.

Source files
------------

// File: rtl/mc_control_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM state
// encodings, ALU operation codes, next-PC select codes and instruction classes.
package mc_defs;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000001;
  localparam logic [5:0] OP_MOV  = 6'b010000;
  localparam logic [5:0] OP_ADD  = 6'b010010;
  localparam logic [5:0] OP_SUB  = 6'b010011;
  localparam logic [5:0] OP_OR   = 6'b010100;
  localparam logic [5:0] OP_AND  = 6'b010101;
  localparam logic [5:0] OP_SLT  = 6'b010111;
  localparam logic [5:0] OP_BNE  = 6'b100001;
  localparam logic [5:0] OP_ADDI = 6'b110010;
  localparam logic [5:0] OP_SUBI = 6'b110011;
  localparam logic [5:0] OP_ORI  = 6'b110100;
  localparam logic [5:0] OP_ANDI = 6'b110101;
  localparam logic [5:0] OP_SLTI = 6'b110111;
  localparam logic [5:0] OP_LI   = 6'b111001;
  localparam logic [5:0] OP_LWI  = 6'b111011;
  localparam logic [5:0] OP_SWI  = 6'b111100;

  // FSM states; the encoding is visible on the debug state port
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_EXEC_LS = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB      = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9
  } state_t;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_OR     = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_SLT    = 3'd4;
  localparam logic [2:0] ALU_PASS_A = 3'd5;
  localparam logic [2:0] ALU_PASS_B = 3'd6;

  // Next-PC select codes
  localparam logic [1:0] PC_INC = 2'd0;  // PC + 1
  localparam logic [1:0] PC_REL = 2'd1;  // incremented PC + sext(imm)
  localparam logic [1:0] PC_ABS = 2'd2;  // imm as absolute target

  // Instruction classes, chosen so each class has one path through the FSM
  typedef enum logic [2:0] {
    CL_NOP = 3'd0,
    CL_R   = 3'd1,
    CL_I   = 3'd2,
    CL_LW  = 3'd3,
    CL_SW  = 3'd4,
    CL_BNE = 3'd5,
    CL_J   = 3'd6,
    CL_ILL = 3'd7
  } iclass_t;

endpackage

// File: rtl/mc_opdecode.sv
// Combinational opcode decoder: instruction class, ALU operation, immediate
// extension and illegal indication. No state, zero latency.
module mc_opdecode
  import mc_defs::*;
(
  input  logic [5:0] opcode_i,
  output iclass_t    cls_o,
  output logic [2:0] alu_op_o,
  output logic       imm_zext_o,
  output logic       illegal_o
);

  // Table lookup of the opcode; anything not listed is illegal
  always_comb begin
    cls_o      = CL_ILL;
    alu_op_o   = ALU_ADD;
    imm_zext_o = 1'b0;
    case (opcode_i)
      OP_NOP:  cls_o = CL_NOP;
      OP_J:    cls_o = CL_J;
      OP_BNE:  begin cls_o = CL_BNE; alu_op_o = ALU_SUB; end
      OP_MOV:  begin cls_o = CL_R;   alu_op_o = ALU_PASS_A; end
      OP_ADD:  begin cls_o = CL_R;   alu_op_o = ALU_ADD; end
      OP_SUB:  begin cls_o = CL_R;   alu_op_o = ALU_SUB; end
      OP_OR:   begin cls_o = CL_R;   alu_op_o = ALU_OR; end
      OP_AND:  begin cls_o = CL_R;   alu_op_o = ALU_AND; end
      OP_SLT:  begin cls_o = CL_R;   alu_op_o = ALU_SLT; end
      OP_ADDI: begin cls_o = CL_I;   alu_op_o = ALU_ADD; end
      OP_SUBI: begin cls_o = CL_I;   alu_op_o = ALU_SUB; end
      OP_ORI:  begin cls_o = CL_I;   alu_op_o = ALU_OR;  imm_zext_o = 1'b1; end
      OP_ANDI: begin cls_o = CL_I;   alu_op_o = ALU_AND; imm_zext_o = 1'b1; end
      OP_SLTI: begin cls_o = CL_I;   alu_op_o = ALU_SLT; end
      OP_LI:   begin cls_o = CL_I;   alu_op_o = ALU_PASS_B; end
      // Loads/stores use the zero-extended immediate as the address
      OP_LWI:  begin cls_o = CL_LW;  alu_op_o = ALU_PASS_B; imm_zext_o = 1'b1; end
      OP_SWI:  begin cls_o = CL_SW;  alu_op_o = ALU_PASS_B; imm_zext_o = 1'b1; end
      default: cls_o = CL_ILL;
    endcase
  end

  assign illegal_o = (cls_o == CL_ILL);

endmodule

// File: rtl/mc_control.sv
// Multicycle Moore control FSM with retired-instruction counter and sticky
// illegal flag. Outputs decode from state and opcode in the same cycle; no
// backpressure. rst (async, active-high) forces FETCH and masks all strobes.
module mc_control
  import mc_defs::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      opcode,
  input  logic            zero,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            alu_src_b,
  output logic            imm_zext,
  output logic            rb_sel,
  output logic [2:0]      alu_op,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            mem_read,
  output logic            mem_write,
  output logic [3:0]      state,
  output logic [PC_W-1:0] instr_count,
  output logic            illegal
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] count_q, count_d;
  logic            illegal_q, illegal_d;

  iclass_t         dec_cls;
  logic [2:0]      dec_alu_op;
  logic            dec_zext;
  logic            dec_illegal;

  mc_opdecode u_opdecode (
    .opcode_i   (opcode),
    .cls_o      (dec_cls),
    .alu_op_o   (dec_alu_op),
    .imm_zext_o (dec_zext),
    .illegal_o  (dec_illegal)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: DECODE dispatches on class, every terminal step returns to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (dec_cls)
          CL_R:    state_d = S_EXEC_R;
          CL_I:    state_d = S_EXEC_I;
          CL_LW:   state_d = S_EXEC_LS;
          CL_SW:   state_d = S_EXEC_LS;
          CL_BNE:  state_d = S_BRANCH;
          CL_J:    state_d = S_JUMP;
          default: state_d = S_FETCH;  // NOP and illegal retire immediately
        endcase
      end
      S_EXEC_R:  state_d = S_WB;
      S_EXEC_I:  state_d = S_WB;
      S_EXEC_LS: state_d = (dec_cls == CL_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = S_WB;
      default:   state_d = S_FETCH;    // MEM_WR, WB, BRANCH, JUMP
    endcase
  end

  // Retire counter and sticky illegal flag next-state
  always_comb begin
    count_d   = count_q;
    illegal_d = illegal_q;
    // Entering FETCH from any other state marks one retired instruction
    if (state_q != S_FETCH && state_d == S_FETCH) begin
      count_d = count_q + PC_W'(1);
    end
    if (state_q == S_DECODE && dec_illegal) begin
      illegal_d = 1'b1;
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore output decode; strobes are masked combinationally while rst is high
  // so that FETCH's strobes do not fire during reset
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_INC;
    alu_src_b  = 1'b0;
    imm_zext   = 1'b0;
    rb_sel     = 1'b0;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_INC;
        end
        S_EXEC_R: begin
          alu_op = dec_alu_op;
        end
        S_EXEC_I: begin
          alu_src_b = 1'b1;
          imm_zext  = dec_zext;
          alu_op    = dec_alu_op;
        end
        S_EXEC_LS: begin
          alu_src_b = 1'b1;
          imm_zext  = 1'b1;
          alu_op    = ALU_PASS_B;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          rb_sel    = 1'b1;  // store data register is IR[25:21]
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (dec_cls == CL_LW);
        end
        S_BRANCH: begin
          alu_op   = ALU_SUB;
          rb_sel   = 1'b1;
          pc_src   = PC_REL;
          pc_write = ~zero;
        end
        S_JUMP: begin
          pc_src   = PC_ABS;
          pc_write = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: an instruction-level model (class,
// step within the instruction) predicts every output each cycle.
module tb_mc_control;
  import mc_defs::*;

  localparam int PC_W = 8;  // narrow counter so the wrap is reachable quickly
  localparam int CMASK = (1 << PC_W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      opcode;
  logic            zero;
  logic            ir_write, pc_write, alu_src_b, imm_zext, rb_sel;
  logic [1:0]      pc_src;
  logic [2:0]      alu_op;
  logic            reg_write, mem_to_reg, mem_read, mem_write;
  logic [3:0]      state;
  logic [PC_W-1:0] instr_count;
  logic            illegal;

  mc_control #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .rb_sel(rb_sel),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write), .state(state),
    .instr_count(instr_count), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instruction classes: 0 NOP, 1 reg ALU, 2 imm ALU, 3 LWI, 4 SWI, 5 BNE, 6 J, 7 illegal
  function automatic int klass(input logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b010000, 6'b010010, 6'b010011, 6'b010100, 6'b010101, 6'b010111: return 1;
      6'b110010, 6'b110011, 6'b110100, 6'b110101, 6'b110111, 6'b111001: return 2;
      6'b111011: return 3;
      6'b111100: return 4;
      6'b100001: return 5;
      6'b000001: return 6;
      default:   return 7;
    endcase
  endfunction

  function automatic int instr_len(input logic [5:0] op);
    case (klass(op))
      0, 7:    return 2;
      5, 6:    return 3;
      3:       return 5;
      default: return 4;
    endcase
  endfunction

  // ALU op named by the mnemonic: MOV->PASS_A, LI->PASS_B, otherwise the arithmetic
  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      6'b010000: return 3'd5;
      6'b111001: return 3'd6;
      6'b010010, 6'b110010: return 3'd0;
      6'b010011, 6'b110011: return 3'd1;
      6'b010100, 6'b110100: return 3'd2;
      6'b010101, 6'b110101: return 3'd3;
      default:   return 3'd4;
    endcase
  endfunction

  typedef struct packed {
    logic       ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_b, imm_zext, rb_sel;
    logic [2:0] alu_op;
    logic       reg_write, mem_to_reg, mem_read, mem_write;
    logic [3:0] st;
  } outs_t;

  function automatic outs_t exp_outs(input logic r, input logic [5:0] op,
                                     input int step, input logic z);
    outs_t o;
    int c;
    o = '0;
    o.st = S_FETCH;
    c = klass(op);
    if (r) return o;
    case (step)
      0: begin o.ir_write = 1; o.pc_write = 1; end
      1: o.st = S_DECODE;
      2: begin
        case (c)
          1: begin o.st = S_EXEC_R; o.alu_op = alu_of(op); end
          2: begin
            o.st = S_EXEC_I; o.alu_src_b = 1; o.alu_op = alu_of(op);
            o.imm_zext = (op == 6'b110100 || op == 6'b110101);
          end
          3, 4: begin o.st = S_EXEC_LS; o.alu_src_b = 1; o.imm_zext = 1; o.alu_op = 3'd6; end
          5: begin o.st = S_BRANCH; o.alu_op = 3'd1; o.rb_sel = 1; o.pc_src = 2'd1; o.pc_write = ~z; end
          default: begin o.st = S_JUMP; o.pc_src = 2'd2; o.pc_write = 1; end
        endcase
      end
      3: begin
        case (c)
          3: begin o.st = S_MEM_RD; o.mem_read = 1; end
          4: begin o.st = S_MEM_WR; o.mem_write = 1; o.rb_sel = 1; end
          default: begin o.st = S_WB; o.reg_write = 1; end
        endcase
      end
      default: begin o.st = S_WB; o.reg_write = 1; o.mem_to_reg = 1; end
    endcase
    return o;
  endfunction

  // Model state: current instruction, step within it, retire count, sticky flag
  logic       m_rst = 1'b1;
  logic [5:0] m_op  = '0;
  int         m_step = 0;
  int         m_count = 0;
  logic       m_ill = 1'b0;
  logic       cmp_en = 1'b1;

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      outs_t e;
      e = exp_outs(m_rst, m_op, m_step, zero);
      chk("state",      int'(state),      int'(e.st));
      chk("ir_write",   int'(ir_write),   int'(e.ir_write));
      chk("pc_write",   int'(pc_write),   int'(e.pc_write));
      chk("pc_src",     int'(pc_src),     int'(e.pc_src));
      chk("alu_src_b",  int'(alu_src_b),  int'(e.alu_src_b));
      chk("imm_zext",   int'(imm_zext),   int'(e.imm_zext));
      chk("rb_sel",     int'(rb_sel),     int'(e.rb_sel));
      chk("alu_op",     int'(alu_op),     int'(e.alu_op));
      chk("reg_write",  int'(reg_write),  int'(e.reg_write));
      chk("mem_to_reg", int'(mem_to_reg), int'(e.mem_to_reg));
      chk("mem_read",   int'(mem_read),   int'(e.mem_read));
      chk("mem_write",  int'(mem_write),  int'(e.mem_write));
      chk("instr_count", int'(instr_count), m_rst ? 0 : m_count);
      chk("illegal",    int'(illegal),    m_rst ? 0 : int'(m_ill));
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge with the DUT in FETCH; returns likewise.
  // zmode: 0/1 hold zero at that value, 2 randomise it every cycle.
  task automatic run_instr(input logic [5:0] op, input int zmode);
    int len;
    len = instr_len(op);
    opcode = op;
    m_op = op;
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      m_step = k;
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    end
    @(posedge clk); #1;
    m_count = (m_count + 1) & CMASK;
    if (klass(op) == 7) m_ill = 1'b1;
    m_step = 0;
  endtask

  // Count cycles until the DUT is back in FETCH, independently of the model
  task automatic measure(input string name, input logic [5:0] op, input int exp);
    int n;
    cmp_en = 1'b0;
    opcode = op;
    zero = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (state != 4'd0 && n < 12);
    chk(name, n, exp);
    m_count = (m_count + 1) & CMASK;
    cmp_en = 1'b1;
  endtask

  logic [5:0] legal_ops [16] = '{6'b000000, 6'b000001, 6'b010000, 6'b010010,
                                 6'b010011, 6'b010100, 6'b010101, 6'b010111,
                                 6'b100001, 6'b110010, 6'b110011, 6'b110100,
                                 6'b110101, 6'b110111, 6'b111001, 6'b111011};

  initial begin
    rst = 1'b1;
    opcode = 6'd0;
    zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, literal
    chk("rst_state", int'(state), 0);
    chk("rst_ir_write", int'(ir_write), 0);
    chk("rst_count", int'(instr_count), 0);
    chk("rst_illegal", int'(illegal), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_rst = 1'b0;
    // First fetch strobe in the first cycle out of reset
    #1 chk("first_fetch", int'(ir_write), 1);

    run_instr(6'b110010, 2);                 // ADDI
    chk("addi_count", int'(instr_count), 1);
    run_instr(6'b111011, 2);                 // LWI
    run_instr(6'b111100, 2);                 // SWI
    run_instr(6'b100001, 0);                 // BNE taken
    run_instr(6'b100001, 1);                 // BNE not taken
    run_instr(6'b000001, 2);                 // J
    run_instr(6'b000000, 2);                 // NOP
    run_instr(6'b111111, 2);                 // illegal
    chk("ill_set", int'(illegal), 1);
    run_instr(6'b110010, 2);                 // ADDI after illegal
    chk("ill_sticky", int'(illegal), 1);
    chk("count9", int'(instr_count), 9);

    measure("cyc_lwi", 6'b111011, 5);
    measure("cyc_swi", 6'b111100, 4);
    measure("cyc_bne", 6'b100001, 3);
    measure("cyc_j",   6'b000001, 3);
    measure("cyc_nop", 6'b000000, 2);
    measure("cyc_add", 6'b010010, 4);

    // Reset in the middle of an LWI, while in MEM_RD
    opcode = 6'b111011;
    m_op = 6'b111011;
    m_step = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      m_step = k;
    end
    #2;
    rst = 1'b1;
    m_rst = 1'b1;
    m_count = 0;
    m_ill = 1'b0;
    #1;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_mem_read", int'(mem_read), 0);
    chk("mid_rst_ir_write", int'(ir_write), 0);
    chk("mid_rst_count", int'(instr_count), 0);
    chk("mid_rst_illegal", int'(illegal), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_rst = 1'b0;
    run_instr(6'b010000, 2);                 // MOV after reset
    chk("post_rst_count", int'(instr_count), 1);

    // Randomised instruction stream, including occasional illegal opcodes
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 15) == 0) op = 6'b111100;  // SWI is not in the table
      run_instr(op, 2);
    end

    // Counter wrap from all-ones to zero
    for (int i = 0; i < 300 && m_count != CMASK; i++) run_instr(6'b000000, 2);
    chk("count_max", int'(instr_count), CMASK);
    run_instr(6'b110010, 2);
    chk("count_wrap", int'(instr_count), 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
